// File: rtl/multi_byte_compare_ctrl.sv
// Byte-serial magnitude comparator: walks two NBYTES-wide operands MSB byte first through one 8-bit cascade slice.
// Define SIGNED_CMP_EN to treat the operands as two's-complement.

module byte_cmp_slice (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       lt_i,
  input  logic       eq_i,
  input  logic       gt_i,
  output logic       lt_o,
  output logic       eq_o,
  output logic       gt_o
);

  // Local magnitude decides; ties defer to the cascade inputs
  always_comb begin
    lt_o = 1'b0;
    eq_o = 1'b0;
    gt_o = 1'b0;
    if (a_i > b_i) begin
      gt_o = 1'b1;
    end else if (a_i < b_i) begin
      lt_o = 1'b1;
    end else begin
      lt_o = lt_i;
      eq_o = eq_i;
      gt_o = gt_i;
    end
  end

endmodule

module multi_byte_compare_ctrl #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic                  lt,
  output logic                  eq,
  output logic                  gt,
  output logic [7:0]            bytes_used
);

  localparam int unsigned W        = 8 * NBYTES;
  localparam logic [7:0]  IDX_LAST = 8'(NBYTES - 1);
  localparam logic [7:0]  NB_CNT   = 8'(NBYTES);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CMP  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   ra_q, ra_d, rb_q, rb_d;
  logic [7:0]     idx_q, idx_d, count_q, count_d, used_q, used_d;
  logic           done_q, done_d, lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;
  logic [7:0]     byte_a_s, byte_b_s;
  logic           slice_lt_s, slice_eq_s, slice_gt_s;

  // Select the current byte pair; in signed mode the MSB byte's sign bit is flipped
  always_comb begin
    byte_a_s = 8'h00;
    byte_b_s = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      byte_a_s = (idx_q == 8'(i)) ? ra_q[8*i +: 8] : byte_a_s;
      byte_b_s = (idx_q == 8'(i)) ? rb_q[8*i +: 8] : byte_b_s;
    end
`ifdef SIGNED_CMP_EN
    byte_a_s[7] = byte_a_s[7] ^ (idx_q == IDX_LAST);
    byte_b_s[7] = byte_b_s[7] ^ (idx_q == IDX_LAST);
`endif
  end

  byte_cmp_slice u_slice (
    .a_i  (byte_a_s),
    .b_i  (byte_b_s),
    .lt_i (1'b0),
    .eq_i (1'b1),
    .gt_i (1'b0),
    .lt_o (slice_lt_s),
    .eq_o (slice_eq_s),
    .gt_o (slice_gt_s)
  );

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      idx_q   <= 8'd0;
      count_q <= 8'd0;
      done_q  <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      used_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      done_q  <= done_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      used_q  <= used_d;
    end
  end

  // Next-state logic: accept in IDLE, one byte per cycle in CMP, exit on first difference
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    idx_d   = idx_q;
    count_d = count_q;
    done_d  = 1'b0;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    used_d  = used_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          idx_d   = IDX_LAST;
          count_d = 8'd0;
          state_d = S_CMP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CMP: begin
        count_d = count_q + 8'd1;
        if (!slice_eq_s) begin
          lt_d    = slice_lt_s;
          eq_d    = 1'b0;
          gt_d    = slice_gt_s;
          used_d  = count_q + 8'd1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (idx_q == 8'd0) begin
          lt_d    = 1'b0;
          eq_d    = 1'b1;
          gt_d    = 1'b0;
          used_d  = NB_CNT;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q - 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy       = (state_q == S_CMP);
  assign done       = done_q;
  assign lt         = lt_q;
  assign eq         = eq_q;
  assign gt         = gt_q;
  assign bytes_used = used_q;

endmodule

// File: tb/tb_multi_byte_compare_ctrl.sv
// Directed and random bench for multi_byte_compare_ctrl at NBYTES = 4, 1 and 8.

module tb_multi_byte_compare_ctrl;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [63:0] a8, b8;
  logic [31:0] a4, b4;
  logic [7:0]  a1, b1;
  logic        busy1, done1, lt1, eq1, gt1;
  logic        busy4, done4, lt4, eq4, gt4;
  logic        busy8, done8, lt8, eq8, gt8;
  logic [7:0]  used1, used4, used8;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  multi_byte_compare_ctrl #(.NBYTES(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .lt(lt4), .eq(eq4), .gt(gt4), .bytes_used(used4));

  multi_byte_compare_ctrl #(.NBYTES(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .lt(lt1), .eq(eq1), .gt(gt1), .bytes_used(used1));

  multi_byte_compare_ctrl #(.NBYTES(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .lt(lt8), .eq(eq8), .gt(gt8), .bytes_used(used8));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: flags {lt,eq,gt} and number of byte compares
  function automatic void model(input logic [63:0] x, input logic [63:0] y, input int nb,
                                output logic [2:0] f, output int used);
    logic [7:0] bx, by;
    logic       found;
    f = 3'b010;
    used = nb;
    found = 1'b0;
    for (int i = nb - 1; i >= 0; i--) begin
      bx = x[8*i +: 8];
      by = y[8*i +: 8];
`ifdef SIGNED_CMP_EN
      if (i == nb - 1) begin
        bx[7] = ~bx[7];
        by[7] = ~by[7];
      end
`endif
      if (!found && bx != by) begin
        found = 1'b1;
        f = (bx < by) ? 3'b100 : 3'b001;
        used = nb - i;
      end
    end
  endfunction

  task automatic start_op(input logic [63:0] av, input logic [63:0] bv);
    a8 = av; b8 = bv;
    a4 = av[31:0]; b4 = bv[31:0];
    a1 = av[7:0]; b1 = bv[7:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the negedge where done4 is high; n is the sample index after the start edge
  task automatic wait_done4(output int n, output int nbusy);
    n = 1;
    nbusy = 0;
    while (!done4 && n < 300) begin
      if (busy4) nbusy++;
      @(negedge clk);
      n++;
    end
    check_eq("done_seen", done4, 1);
  endtask

  task automatic run_all(input logic [63:0] av, input logic [63:0] bv);
    int d1, d4, d8, u;
    logic [2:0] f;
    d1 = 0; d4 = 0; d8 = 0;
    start_op(av, bv);
    for (int n = 1; n <= 12; n++) begin
      if (done1 && d1 == 0) d1 = n;
      if (done4 && d4 == 0) d4 = n;
      if (done8 && d8 == 0) d8 = n;
      if (d1 != 0 && d4 != 0 && d8 != 0) break;
      @(negedge clk);
    end
    model(av, bv, 1, f, u);
    check_eq("r1_flags", {lt1, eq1, gt1}, 64'(f));
    check_eq("r1_used", used1, 64'(u));
    check_eq("r1_lat", 64'(d1), 64'(u + 1));
    model(av, bv, 4, f, u);
    check_eq("r4_flags", {lt4, eq4, gt4}, 64'(f));
    check_eq("r4_used", used4, 64'(u));
    check_eq("r4_lat", 64'(d4), 64'(u + 1));
    check_eq("r4_onehot", 64'($countones({lt4, eq4, gt4})), 1);
    model(av, bv, 8, f, u);
    check_eq("r8_flags", {lt8, eq8, gt8}, 64'(f));
    check_eq("r8_used", used8, 64'(u));
    check_eq("r8_lat", 64'(d8), 64'(u + 1));
  endtask

  initial begin
    int n, nb, dcount, p;
    logic [63:0] ra, rb;
    reset = 1'b1;
    start = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", busy4, 0);
    check_eq("rst_done", done4, 0);
    check_eq("rst_flags", {lt4, eq4, gt4}, 0);
    check_eq("rst_used", used4, 0);
    reset = 1'b0;
    @(negedge clk);

    // Equal operands: full walk
    start_op(64'h12345678, 64'h12345678);
    wait_done4(n, nb);
    check_eq("eq_lat", 64'(n), 5);
    check_eq("eq_busy", 64'(nb), 4);
    check_eq("eq_flags", {lt4, eq4, gt4}, 3'b010);
    check_eq("eq_used", used4, 4);
    @(negedge clk);
    check_eq("eq_pulse", done4, 0);

    // MSB byte decides
    start_op(64'h80000000, 64'h7FFFFFFF);
    wait_done4(n, nb);
    check_eq("msb_lat", 64'(n), 2);
`ifdef SIGNED_CMP_EN
    check_eq("msb_flags", {lt4, eq4, gt4}, 3'b100);
`else
    check_eq("msb_flags", {lt4, eq4, gt4}, 3'b001);
`endif
    check_eq("msb_used", used4, 1);
    @(negedge clk);

    // LSB byte decides, then back-to-back start in the done cycle
    start_op(64'hAABBCC01, 64'hAABBCC02);
    wait_done4(n, nb);
    check_eq("lsb_lat", 64'(n), 5);
    check_eq("lsb_flags", {lt4, eq4, gt4}, 3'b100);
    check_eq("lsb_used", used4, 4);
    start_op(64'h0, 64'h0);
    check_eq("b2b_busy", busy4, 1);
    check_eq("b2b_held", {lt4, eq4, gt4}, 3'b100);
    wait_done4(n, nb);
    check_eq("b2b_flags", {lt4, eq4, gt4}, 3'b010);
    check_eq("b2b_used", used4, 4);
    @(negedge clk);

    // start and operand changes during CMP are ignored
    start_op(64'd5, 64'd9);
    start = 1'b1;
    a4 = 32'd9;
    b4 = 32'd5;
    @(negedge clk);
    start = 1'b0;
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      if (done4) dcount++;
      @(negedge clk);
    end
    check_eq("mid_pulses", 64'(dcount), 1);
    check_eq("mid_flags", {lt4, eq4, gt4}, 3'b100);
    check_eq("mid_used", used4, 4);

    // Reset in the second CMP cycle abandons the operation
    start_op(64'h01020304, 64'h01020305);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("ab_busy", busy4, 0);
    check_eq("ab_done", done4, 0);
    check_eq("ab_flags", {lt4, eq4, gt4}, 0);
    check_eq("ab_used", used4, 0);
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      if (done4) dcount++;
      @(negedge clk);
    end
    check_eq("ab_nopulse", 64'(dcount), 0);
    start_op(64'h01020304, 64'h01020305);
    wait_done4(n, nb);
    check_eq("ab_restart_lat", 64'(n), 5);
    check_eq("ab_restart_flags", {lt4, eq4, gt4}, 3'b100);
    check_eq("ab_restart_used", used4, 4);

    // Random pairs with a controlled number of leading equal bytes
    repeat (12) @(negedge clk);
    for (int k = 0; k < 200; k++) begin
      ra = {$urandom, $urandom};
      rb = ra;
      p = $urandom_range(0, 8);
      if (p < 8) rb[8*p +: 8] = 8'($urandom);
      if (k % 5 == 0) rb = {$urandom, $urandom};
      run_all(ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
